// File: rtl/service_mode_arbiter_if.sv
// Bundle between the service arbiter and its surroundings: raw switches and buttons,
// service display buses, and the grant/display outputs.
interface service_mode_arbiter_if;
  logic [3:0]  spdt_service;
  logic [4:0]  push;
  logic [3:0]  finish;
  logic [63:0] num_bus;
  logic [15:0] sel_bus;
  logic [15:0] current_time;
  logic [3:0]  svc_en;
  logic [4:0]  push_pulse;
  logic [15:0] disp_num;
  logic [3:0]  disp_sel;
  logic [3:0]  spdt_led;
  logic        err;

  modport slave (
    input  spdt_service, push, finish, num_bus, sel_bus, current_time,
    output svc_en, push_pulse, disp_num, disp_sel, spdt_led, err
  );

  modport master (
    output spdt_service, push, finish, num_bus, sel_bus, current_time,
    input  svc_en, push_pulse, disp_num, disp_sel, spdt_led, err
  );
endinterface

// File: rtl/service_mode_arbiter.sv
// Grants the shared display and buttons to exactly one service, selected by debounced
// SPDT switches, with finish handshake, display hold and break-before-make hand-over.
module service_mode_arbiter #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter logic [3:0]  ERR_DIGIT     = 4'hE
) (
  input  logic                  clk,
  input  logic                  resetn,
  service_mode_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(STABLE_CYCLES - 1);

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1000: idx = 2'd3;
      4'b0100: idx = 2'd2;
      4'b0010: idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  logic [3:0]  sample_q, cnt_q, cnt_d, sw_q, sw_d;
  logic [1:0]  state_q, state_d, owner_q, owner_d;
  logic [15:0] hold_q, hold_d;
  logic [4:0]  push_q, push_edge_s;
  logic [15:0] owner_num_s;
  logic [3:0]  owner_sel_s;

  logic [3:0]  svc_en_q, svc_en_d;
  logic [4:0]  push_pulse_q, push_pulse_d;
  logic [15:0] disp_num_q, disp_num_d;
  logic [3:0]  disp_sel_q, disp_sel_d;
  logic        err_q, err_d;

  assign owner_num_s = bus.num_bus[{owner_q, 4'b0000} +: 16];
  assign owner_sel_s = bus.sel_bus[{owner_q, 2'b00} +: 4];
  assign push_edge_s = bus.push & ~push_q;

  // Switch filter: a pattern is accepted once it has been seen unchanged long enough.
  always_comb begin
    cnt_d = cnt_q;
    sw_d  = sw_q;
    if (bus.spdt_service != sample_q) begin
      cnt_d = 4'd0;
    end else if (cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (cnt_d == CNT_LOAD) begin
      sw_d = bus.spdt_service;
    end else begin
      sw_d = sw_q;
    end
  end

  // Mode FSM; a switch change in RUN always beats a same-cycle finish.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (is_onehot(sw_q)) begin
          state_d = S_RUN;
          owner_d = onehot_to_idx(sw_q);
        end else if (sw_q != 4'b0000) begin
          state_d = S_ERR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (sw_q != idx_to_onehot(owner_q)) begin
          state_d = S_IDLE;
        end else if (bus.finish[owner_q]) begin
          state_d = S_DONE;
          hold_d  = owner_num_s;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE, S_ERR: begin
        if (sw_q == 4'b0000) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values, derived from the current state.
  always_comb begin
    svc_en_d     = 4'b0000;
    push_pulse_d = 5'b00000;
    disp_sel_d   = 4'b0000;
    err_d        = 1'b0;
    disp_num_d   = 16'h0000;
    case (state_q)
      S_IDLE: disp_num_d = bus.current_time;
      S_RUN: begin
        svc_en_d     = idx_to_onehot(owner_q);
        push_pulse_d = push_edge_s;
        disp_num_d   = owner_num_s;
        if (owner_q[1]) begin
          disp_sel_d = owner_sel_s;
        end else begin
          disp_sel_d = 4'b0000;
        end
      end
      S_DONE: disp_num_d = hold_q;
      S_ERR: begin
        disp_num_d = {4{ERR_DIGIT}};
        err_d      = 1'b1;
      end
      default: disp_num_d = 16'h0000;
    endcase
  end

  // State, filter and button history registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample_q <= 4'b0000;
      cnt_q    <= 4'd0;
      sw_q     <= 4'b0000;
      state_q  <= S_IDLE;
      owner_q  <= 2'd0;
      hold_q   <= 16'h0000;
      push_q   <= 5'b00000;
    end else begin
      sample_q <= bus.spdt_service;
      cnt_q    <= cnt_d;
      sw_q     <= sw_d;
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      push_q   <= bus.push;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      svc_en_q     <= 4'b0000;
      push_pulse_q <= 5'b00000;
      disp_num_q   <= 16'h0000;
      disp_sel_q   <= 4'b0000;
      err_q        <= 1'b0;
    end else begin
      svc_en_q     <= svc_en_d;
      push_pulse_q <= push_pulse_d;
      disp_num_q   <= disp_num_d;
      disp_sel_q   <= disp_sel_d;
      err_q        <= err_d;
    end
  end

  assign bus.svc_en     = svc_en_q;
  assign bus.spdt_led   = svc_en_q;
  assign bus.push_pulse = push_pulse_q;
  assign bus.disp_num   = disp_num_q;
  assign bus.disp_sel   = disp_sel_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_service_mode_arbiter.sv
// Directed bench for service_mode_arbiter: a vector table for steady-state behaviour plus
// hand-written sequences for button edges, hand-over, glitches and asynchronous reset.
module tb_service_mode_arbiter;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  service_mode_arbiter_if bus ();

  service_mode_arbiter #(
    .STABLE_CYCLES (3),
    .ERR_DIGIT     (4'hE)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]  spdt;
    logic [3:0]  fin;
    logic [15:0] n1;
    logic [15:0] n2;
    int          cyc;
    logic [3:0]  en;
    logic [15:0] disp;
    logic [3:0]  sel;
    logic        err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_num(input logic [15:0] n1, input logic [15:0] n2);
    bus.num_bus = {n1, n2, 16'h3333, 16'h4444};
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] en, input logic [15:0] disp,
                          input logic [3:0] sel, input logic e, input logic [4:0] pp);
    chk({tag, "_svc_en"},     {12'h000, bus.svc_en},     {12'h000, en});
    chk({tag, "_spdt_led"},   {12'h000, bus.spdt_led},   {12'h000, en});
    chk({tag, "_disp_num"},   bus.disp_num,              disp);
    chk({tag, "_disp_sel"},   {12'h000, bus.disp_sel},   {12'h000, sel});
    chk({tag, "_err"},        {15'h0000, bus.err},       {15'h0000, e});
    chk({tag, "_push_pulse"}, {11'h000, bus.push_pulse}, {11'h000, pp});
  endtask

  task automatic count_pulses(input logic [4:0] pattern, input int n, output int cnt);
    cnt = 0;
    bus.push = pattern;
    repeat (n) begin
      tick(1);
      if (bus.push_pulse == pattern) cnt++;
      else if (bus.push_pulse != 5'b00000) cnt += 100;
    end
    bus.push = 5'b00000;
    tick(2);
  endtask

  initial begin
    int c;
    int phase;
    int bad;
    int seen;

    vecs[0]  = '{4'b0000, 4'b0000, 16'h1234, 16'h0730, 2, 4'b0000, 16'h0959, 4'h0, 1'b0};
    vecs[1]  = '{4'b1000, 4'b0000, 16'h1234, 16'h0730, 4, 4'b0000, 16'h0959, 4'h0, 1'b0};
    vecs[2]  = '{4'b1000, 4'b0000, 16'h1234, 16'h0730, 1, 4'b1000, 16'h1234, 4'hA, 1'b0};
    vecs[3]  = '{4'b1000, 4'b0000, 16'h1235, 16'h0730, 1, 4'b1000, 16'h1235, 4'hA, 1'b0};
    vecs[4]  = '{4'b1000, 4'b1000, 16'h1235, 16'h0730, 2, 4'b0000, 16'h1235, 4'h0, 1'b0};
    vecs[5]  = '{4'b1000, 4'b0000, 16'h9999, 16'h0730, 2, 4'b0000, 16'h1235, 4'h0, 1'b0};
    vecs[6]  = '{4'b0000, 4'b0000, 16'h1234, 16'h0730, 6, 4'b0000, 16'h0959, 4'h0, 1'b0};
    vecs[7]  = '{4'b0100, 4'b0000, 16'h1234, 16'h0730, 6, 4'b0100, 16'h0730, 4'h5, 1'b0};
    vecs[8]  = '{4'b0100, 4'b0100, 16'h1234, 16'h0730, 2, 4'b0000, 16'h0730, 4'h0, 1'b0};
    vecs[9]  = '{4'b0100, 4'b0000, 16'h1234, 16'h1111, 2, 4'b0000, 16'h0730, 4'h0, 1'b0};
    vecs[10] = '{4'b0000, 4'b0000, 16'h1234, 16'h0730, 6, 4'b0000, 16'h0959, 4'h0, 1'b0};
    vecs[11] = '{4'b1100, 4'b0000, 16'h1234, 16'h0730, 6, 4'b0000, 16'hEEEE, 4'h0, 1'b1};
    vecs[12] = '{4'b0000, 4'b0000, 16'h1234, 16'h0730, 6, 4'b0000, 16'h0959, 4'h0, 1'b0};
    vecs[13] = '{4'b0010, 4'b0000, 16'h1234, 16'h0730, 6, 4'b0010, 16'h3333, 4'h0, 1'b0};
    vecs[14] = '{4'b0010, 4'b1101, 16'h1234, 16'h0730, 2, 4'b0010, 16'h3333, 4'h0, 1'b0};

    resetn           = 1'b0;
    bus.spdt_service = 4'b0000;
    bus.push         = 5'b00000;
    bus.finish       = 4'b0000;
    bus.sel_bus      = 16'hA53C;
    bus.current_time = 16'h0959;
    set_num(16'h1234, 16'h0730);
    tick(2);
    chk_outs("reset", 4'b0000, 16'h0000, 4'h0, 1'b0, 5'b00000);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bus.spdt_service = vecs[i].spdt;
      bus.finish       = vecs[i].fin;
      set_num(vecs[i].n1, vecs[i].n2);
      tick(vecs[i].cyc);
      chk_outs($sformatf("v%0d", i), vecs[i].en, vecs[i].disp, vecs[i].sel, vecs[i].err, 5'b00000);
    end
    bus.finish = 4'b0000;

    // Held button and simultaneous buttons while svc3 owns the display.
    count_pulses(5'b10000, 10, c);
    chk("held_push_pulses", 16'(c), 16'd1);
    count_pulses(5'b10101, 10, c);
    chk("multi_push_pulses", 16'(c), 16'd1);

    // Direct hand-over svc1 -> svc4 must show a gap with no grant.
    bus.spdt_service = 4'b1000;
    tick(8);
    chk("bbm_start", {12'h000, bus.svc_en}, 16'h0008);
    bus.spdt_service = 4'b0001;
    phase = 0;
    bad   = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (bus.svc_en == 4'b0000) begin
        if (phase == 0) begin
          phase      = 1;
          bus.finish = 4'b1000;
        end else if (phase == 2) begin
          bad = 1;
        end
      end else if (bus.svc_en == 4'b0001) begin
        if (phase == 1) phase = 2;
        else if (phase == 0) bad = 1;
      end else if (bus.svc_en != 4'b1000 || phase != 0) begin
        bad = 1;
      end
    end
    chk("bbm_gap_seen", 16'(phase), 16'd2);
    chk("bbm_no_overlap", 16'(bad), 16'd0);
    tick(3);
    chk("bbm_new_owner", {12'h000, bus.svc_en}, 16'h0001);
    chk("bbm_disp", bus.disp_num, 16'h4444);
    bus.finish = 4'b0000;

    // Buttons with no owner are dropped.
    bus.spdt_service = 4'b0000;
    tick(6);
    count_pulses(5'b10000, 10, c);
    chk("idle_push_pulses", 16'(c), 16'd0);

    // Two-cycle switch glitch never reaches the FSM.
    bus.spdt_service = 4'b1000;
    tick(2);
    bus.spdt_service = 4'b0000;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (bus.svc_en != 4'b0000) seen = 1;
    end
    chk("glitch_no_grant", 16'(seen), 16'd0);

    // Asynchronous reset while RUN with a live button pulse.
    bus.spdt_service = 4'b1000;
    tick(6);
    chk("pre_reset_en", {12'h000, bus.svc_en}, 16'h0008);
    bus.push = 5'b10000;
    tick(1);
    chk("pre_reset_pulse", {11'h000, bus.push_pulse}, 16'h0010);
    #2 resetn = 1'b0;
    #1;
    chk_outs("async_reset", 4'b0000, 16'h0000, 4'h0, 1'b0, 5'b00000);
    tick(1);
    resetn   = 1'b1;
    bus.push = 5'b00000;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/service_mode_arbiter.md
Name: service_mode_arbiter

Overview:
Central controller that decides which service (1 time-set, 2 alarm-set, 3 stopwatch, 4 alarm-check) owns the shared 7-segment display and push buttons. Filters the 4 service SPDT switches and runs a mode FSM that grants exactly one service at a time. Handles each service's finish handshake and drives the switch LEDs. Sits in Main between the raw switch/button inputs, the service modules and the segment scanner.

Parameters:
STABLE_CYCLES, 3, consecutive identical clk samples required before a switch pattern is accepted (2..15)
ERR_DIGIT, 4'hE, digit shown on all four positions in the error state

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
spdt_service  in  4  raw service switches; bit3=svc1, bit2=svc2, bit1=svc3, bit0=svc4
push  in  5  raw buttons {m,r,l,d,u}, level
finish  in  4  per-service finish flags, same bit order as spdt_service
num_bus  in  64  service display values; svc at bit i drives num_bus[16*i+15:16*i]
sel_bus  in  16  service digit-select masks; svc at bit i drives sel_bus[4*i+3:4*i]
current_time  in  16  BCD mm:ss from time base
svc_en  out  4  one-hot grant (or 0000)
push_pulse  out  5  one-cycle button rising-edge pulses, owner only
disp_num  out  16  value to segment scanner
disp_sel  out  4  blink mask to segment scanner
spdt_led  out  4  switch indicator LEDs
err  out  1  high in ERR state

Behaviour:
- Reset (async, resetn=0): state IDLE; sw_q=0000; stability counter=0; push_q=00000; all outputs 0.
- Switch filter: cnt resets to 0 when spdt_service differs from the previous-cycle sample, else saturating increment. When cnt reaches STABLE_CYCLES-1, sw_q <= sample. Net acceptance latency: STABLE_CYCLES cycles after the last change.
- FSM states, evaluated each clk on sw_q:
  - IDLE: sw_q=0000 -> stay. One-hot -> RUN, owner <= index. Multi-hot -> ERR.
  - RUN: any sw_q != owner one-hot -> IDLE (break-before-make: at least one cycle with svc_en=0000 between owners). Else finish[owner]=1 -> DONE, snapshot num_bus[owner] into hold register. finish of non-owner bits ignored. Switch change and finish in the same cycle: switch change wins (-> IDLE, no snapshot).
  - DONE: stays until sw_q=0000, then -> IDLE. Re-asserting the same switch without passing through 0000 does not restart the service.
  - ERR: stays until sw_q=0000, then -> IDLE.
- Outputs (all registered, 1 cycle after the state/inputs they reflect):
  - svc_en: owner one-hot in RUN, else 0000.
  - spdt_led: equals svc_en. LEDs are dark in DONE/ERR/IDLE.
  - disp_num: IDLE -> current_time. RUN -> num_bus[owner]. DONE -> hold register. ERR -> {4{ERR_DIGIT}}.
  - disp_sel: RUN with owner svc1 or svc2 -> sel_bus[owner]; otherwise 0000.
  - err: 1 only in ERR.
- Buttons: push_q <= push every cycle; edge = push & ~push_q. push_pulse <= edge when state is RUN, else 00000. Simultaneous edges all pass. Held button: exactly one pulse. Edge during the IDLE gap or DONE is dropped, not queued.
- Reset mid-RUN: svc_en, push_pulse, disp_num drop to 0 immediately (async).

Test Plan:
- Reset, spdt_service=1000 held: svc_en=1000, spdt_led=1000 by cycle 5 after the change (3 filter cycles + FSM + output register); disp_num tracks num_bus[63:48]=16'h1234.
- RUN svc3, push[4] high for 10 cycles -> exactly one push_pulse=10000 pulse; same press with switches 0000 -> no pulse.
- RUN svc2, finish=0100, num_bus[47:32]=16'h0730 -> DONE: svc_en=0000, spdt_led=0000, disp_num stays 0730 after num_bus changes; switch back to 0000 -> disp_num=current_time.
- spdt_service=1100 -> err=1, disp_num=EEEE, svc_en=0000; 0000 then 0010 -> svc_en=0010.
- RUN svc1, switch 1000->0001 in one step -> at least one cycle svc_en=0000, then svc_en=0001. finish=1000 during the gap is ignored.
- Glitch 1000 for 2 cycles, then 0000 -> svc_en never asserts.
- Assert resetn=0 mid-RUN -> all outputs 0 without waiting for a clk edge.
